// File: rtl/gpio_bank.sv
// gpio_bank: NPORTS x 8-bit PacoBlaze3 GPIO with per-bit direction, rising-edge flags and a level irq.
// Latency: writes visible after 1 edge; in_port registered (1 edge); pin-to-flag 3 edges, pin-to-irq 4.
// Backpressure: none; every bus access is accepted and completes in a single clock.
module gpio_bank #(
   parameter logic [7:0] BASE_ADDR = 8'h10,
   parameter int         NPORTS    = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          port_id,
   input  logic [7:0]          out_port,
   input  logic                write_strobe,
   input  logic                read_strobe,
   output logic [7:0]          in_port,
   input  logic [8*NPORTS-1:0] gpio_in,
   output logic [8*NPORTS-1:0] gpio_out,
   output logic [8*NPORTS-1:0] gpio_oe,
   output logic                irq
);
   localparam int         W        = 8*NPORTS;
   localparam logic [7:0] SUM_ADDR = BASE_ADDR + 8'(4*NPORTS);

   logic [W-1:0] out_q, out_d;
   logic [W-1:0] oe_q, oe_d;
   logic [W-1:0] ie_q, ie_d;
   logic [W-1:0] flag_q, flag_d;
   logic [W-1:0] sync1_q, sync2_q, prev_q;
   logic [1:0]   arm_q, arm_d;
   logic [7:0]   in_port_q, rdata_d;
   logic         irq_q, irq_d;

   logic [W-1:0] clr;
   logic [W-1:0] rise;
   logic [7:0]   offs;
   logic [7:0]   summary;
   logic         in_range;
   logic         armed;

   // The bus is a passive observer for reads; read_strobe carries no side effect.
   logic unused_rd;
   assign unused_rd = read_strobe;

   // Address decode, register writes, read mux and flag/irq next-state.
   always_comb begin
      offs     = port_id - BASE_ADDR;
      in_range = (port_id >= BASE_ADDR) && (port_id < SUM_ADDR);
      // Edges are only believed once the synchronizer has been refilled after reset.
      armed    = (arm_q == 2'd3);
      arm_d    = armed ? arm_q : arm_q + 2'd1;
      // prev tracks sync2 regardless of direction, so flipping DIR cannot fake an edge.
      rise     = sync2_q & ~prev_q & ~oe_q & {W{armed}};
      out_d    = out_q;
      oe_d     = oe_q;
      ie_d     = ie_q;
      clr      = '0;
      rdata_d  = 8'h00;
      summary  = 8'h00;
      for (int k = 0; k < NPORTS; k++) begin
         summary[k] = |(flag_q[8*k +: 8] & ie_q[8*k +: 8]);
         if (in_range && (offs[7:2] == 6'(k))) begin
            case (offs[1:0])
               2'd0: begin
                  rdata_d = (oe_q[8*k +: 8] & out_q[8*k +: 8]) |
                            (~oe_q[8*k +: 8] & sync2_q[8*k +: 8]);
                  if (write_strobe) out_d[8*k +: 8] = out_port;
               end
               2'd1: begin
                  rdata_d = oe_q[8*k +: 8];
                  if (write_strobe) oe_d[8*k +: 8] = out_port;
               end
               2'd2: begin
                  rdata_d = ie_q[8*k +: 8];
                  if (write_strobe) ie_d[8*k +: 8] = out_port;
               end
               default: begin
                  rdata_d = flag_q[8*k +: 8];
                  if (write_strobe) clr[8*k +: 8] = out_port;
               end
            endcase
         end
      end
      if (port_id == SUM_ADDR) rdata_d = summary;
      // A new edge in the same cycle as a write-1-clear keeps the flag set.
      flag_d = (flag_q & ~clr) | rise;
      irq_d  = |(flag_q & ie_q);
   end

   // State registers; synchronous reset clears everything including a read in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q     <= '0;
         oe_q      <= '0;
         ie_q      <= '0;
         flag_q    <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         arm_q     <= 2'd0;
         in_port_q <= 8'h00;
         irq_q     <= 1'b0;
      end else begin
         out_q     <= out_d;
         oe_q      <= oe_d;
         ie_q      <= ie_d;
         flag_q    <= flag_d;
         sync1_q   <= gpio_in;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         arm_q     <= arm_d;
         in_port_q <= rdata_d;
         irq_q     <= irq_d;
      end
   end

   assign in_port  = in_port_q;
   assign gpio_out = out_q;
   assign gpio_oe  = oe_q;
   assign irq      = irq_q;
endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed scenarios plus random bus/pin traffic against a behavioural model.
// Latency: model predicts post-edge outputs; DUT is compared on every falling edge.
// Backpressure: not applicable; stimulus is applied one bus cycle per clock.
module tb_gpio_bank;
   localparam logic [7:0] BASE = 8'h10;
   localparam int         NP   = 2;
   localparam int         W    = 8*NP;

   logic         clk;
   logic         rst;
   logic [7:0]   port_id;
   logic [7:0]   out_port;
   logic         write_strobe;
   logic         read_strobe;
   logic [7:0]   in_port;
   logic [W-1:0] gpio_in;
   logic [W-1:0] gpio_out;
   logic [W-1:0] gpio_oe;
   logic         irq;

   gpio_bank #(.BASE_ADDR(BASE), .NPORTS(NP)) dut (
      .clk(clk), .rst(rst), .port_id(port_id), .out_port(out_port),
      .write_strobe(write_strobe), .read_strobe(read_strobe), .in_port(in_port),
      .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: register file per port plus the history of sampled pin words.
   logic [7:0]   m_out[NP];
   logic [7:0]   m_oe[NP];
   logic [7:0]   m_ie[NP];
   logic [7:0]   m_fl[NP];
   logic [W-1:0] hist[$];   // hist[2] newest sample, hist[1] synchronized, hist[0] one older
   int           since;     // clock edges since the last reset edge (saturating)
   logic [7:0]   m_in;
   logic         m_irq;
   bit           m_valid;

   int           vectors;
   int           miscompares;
   logic [W-1:0] pins;

   function automatic logic [7:0] m_read(input logic [7:0] a);
      int         off;
      int         k;
      logic [7:0] r;
      logic [W-1:0] s;
      r   = 8'h00;
      s   = hist[1];
      off = int'(a) - int'(BASE);
      if (off >= 0 && off < 4*NP) begin
         k = off / 4;
         case (off % 4)
            0:       r = (m_oe[k] & m_out[k]) | (~m_oe[k] & s[8*k +: 8]);
            1:       r = m_oe[k];
            2:       r = m_ie[k];
            default: r = m_fl[k];
         endcase
      end else if (off == 4*NP) begin
         for (int j = 0; j < NP; j++) r[j] = |(m_fl[j] & m_ie[j]);
      end
      return r;
   endfunction

   task automatic model_advance(input logic r, input logic [7:0] pid, input logic [7:0] wd,
                                input logic ws, input logic [W-1:0] gin);
      logic [7:0]   rd;
      logic         irq_n;
      logic [W-1:0] s2;
      logic [W-1:0] pv;
      logic [7:0]   rise[NP];
      logic [7:0]   clr[NP];
      int           off;
      int           k;
      if (r) begin
         for (int j = 0; j < NP; j++) begin
            m_out[j] = 8'h00; m_oe[j] = 8'h00; m_ie[j] = 8'h00; m_fl[j] = 8'h00;
         end
         hist.delete();
         for (int j = 0; j < 3; j++) hist.push_back('0);
         since   = 0;
         m_in    = 8'h00;
         m_irq   = 1'b0;
         m_valid = 1'b1;
         return;
      end
      if (!m_valid) return;
      rd    = m_read(pid);
      irq_n = 1'b0;
      s2    = hist[1];
      pv    = hist[0];
      for (int j = 0; j < NP; j++) begin
         irq_n   = irq_n | (|(m_fl[j] & m_ie[j]));
         rise[j] = s2[8*j +: 8] & ~pv[8*j +: 8] & ~m_oe[j] & ((since >= 3) ? 8'hFF : 8'h00);
         clr[j]  = 8'h00;
      end
      off = int'(pid) - int'(BASE);
      if (ws && off >= 0 && off < 4*NP) begin
         k = off / 4;
         case (off % 4)
            0:       m_out[k] = wd;
            1:       m_oe[k]  = wd;
            2:       m_ie[k]  = wd;
            default: clr[k]   = wd;
         endcase
      end
      for (int j = 0; j < NP; j++) m_fl[j] = (m_fl[j] & ~clr[j]) | rise[j];
      void'(hist.pop_front());
      hist.push_back(gin);
      if (since < 3) since++;
      m_in  = rd;
      m_irq = irq_n;
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison of all DUT outputs against the model.
   task automatic check();
      logic [W-1:0] eo;
      logic [W-1:0] ee;
      if (!m_valid) return;
      for (int j = 0; j < NP; j++) begin
         eo[8*j +: 8] = m_out[j];
         ee[8*j +: 8] = m_oe[j];
      end
      cmp("gpio_out", 32'(gpio_out), 32'(eo));
      cmp("gpio_oe",  32'(gpio_oe),  32'(ee));
      cmp("in_port",  32'(in_port),  32'(m_in));
      cmp("irq",      32'(irq),      32'(m_irq));
   endtask

   task automatic step(input logic r, input logic [7:0] pid, input logic [7:0] wd, input logic ws);
      rst          = r;
      port_id      = pid;
      out_port     = wd;
      write_strobe = ws;
      read_strobe  = 1'($urandom_range(0, 1));
      gpio_in      = pins;
      model_advance(r, pid, wd, ws, pins);
      @(posedge clk);
      @(negedge clk);
      check();
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      step(1'b0, a, d, 1'b1);
   endtask

   task automatic rd(input logic [7:0] a);
      step(1'b0, a, 8'h00, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   initial begin
      vectors = 0; miscompares = 0; m_valid = 1'b0;
      rst = 1'b1; port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
      pins = '1; gpio_in = pins;
      @(negedge clk);

      // Reset with every pin high: nothing may flag once the pipeline refills.
      step(1'b1, 8'h00, 8'h00, 1'b0);
      step(1'b1, 8'h00, 8'h00, 1'b0);
      idle(10);
      cmp("rst_gpio_out", 32'(gpio_out), 32'h0);
      cmp("rst_gpio_oe",  32'(gpio_oe),  32'h0);
      cmp("rst_in_port",  32'(in_port),  32'h0);
      cmp("rst_irq",      32'(irq),      32'h0);
      rd(8'h13); cmp("rst_iflag0", 32'(in_port), 32'h00);
      rd(8'h17); cmp("rst_iflag1", 32'(in_port), 32'h00);

      // Output latch and mixed readback on port 0.
      pins[7:0] = 8'h3C;
      wr(8'h11, 8'h0F); cmp("dir0_visible",  32'(gpio_oe[7:0]),  32'h0F);
      wr(8'h10, 8'hA5); cmp("data0_visible", 32'(gpio_out[7:0]), 32'hA5);
      idle(2);
      rd(8'h10); cmp("data0_readback", 32'(in_port), 32'h35);

      // Edge capture, irq and SUMMARY on port 1 bit 0.
      pins[8] = 1'b0; idle(4);
      wr(8'h16, 8'h01);
      pins[8] = 1'b1;
      rd(8'h17);                                        // edge n
      rd(8'h17);                                        // n+1
      rd(8'h17); cmp("iflag1_n2_read", 32'(in_port), 32'h00); cmp("irq_n2", 32'(irq), 32'h0);
      rd(8'h17); cmp("iflag1_set", 32'(in_port), 32'h01);     cmp("irq_n3", 32'(irq), 32'h1);
      rd(8'h18); cmp("summary", 32'(in_port), 32'h02);
      wr(8'h17, 8'h01); cmp("irq_at_clear", 32'(irq), 32'h1);
      idle(1);          cmp("irq_after_clear", 32'(irq), 32'h0);

      // Set/clear collision on port 0 bit 3.
      wr(8'h11, 8'h00);
      wr(8'h13, 8'hFF);
      pins[3] = 1'b0; idle(4);
      pins[3] = 1'b1;
      idle(2);                                           // edges n, n+1
      wr(8'h13, 8'h08);                                  // clear lands with the set at n+2
      rd(8'h13); cmp("collision_set_wins", 32'(in_port), 32'h08);
      wr(8'h13, 8'h08);
      rd(8'h13); cmp("clear_no_edge", 32'(in_port), 32'h00);

      // Direction switch on bit 2: no fabricated edge, real edge still seen.
      wr(8'h10, 8'h00);
      wr(8'h11, 8'h04);
      wr(8'h13, 8'hFF);
      idle(3);
      wr(8'h11, 8'h00);
      idle(4);
      rd(8'h13); cmp("dir_switch_no_flag", 32'(in_port), 32'h00);
      pins[2] = 1'b0; idle(4);
      pins[2] = 1'b1; idle(4);
      rd(8'h13); cmp("dir_switch_real_edge", 32'(in_port), 32'h04);

      // Unmapped address, then reset while irq is asserted.
      rd(8'h19); cmp("unmapped_read", 32'(in_port), 32'h00);
      wr(8'h19, 8'hFF);
      cmp("unmapped_wr_out", 32'(gpio_out), 32'h0);
      cmp("unmapped_wr_oe",  32'(gpio_oe),  32'h0);
      pins[8] = 1'b0; idle(4);
      pins[8] = 1'b1; idle(4);
      cmp("irq_before_reset", 32'(irq), 32'h1);
      step(1'b1, 8'h17, 8'h00, 1'b0);
      cmp("irq_after_reset", 32'(irq), 32'h0);
      rd(8'h13); cmp("iflag0_after_reset", 32'(in_port), 32'h00);
      rd(8'h17); cmp("iflag1_after_reset", 32'(in_port), 32'h00);
      idle(6);
      rd(8'h17); cmp("iflag1_settled", 32'(in_port), 32'h00);

      // Random bus and pin traffic checked cycle by cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         logic       r;
         logic [7:0] pid;
         if ($urandom_range(0, 3) == 0) pins = W'($urandom);
         r   = ($urandom_range(0, 299) == 0);
         pid = BASE - 8'd2 + 8'($urandom_range(0, 4*NP + 4));
         step(r, pid, 8'($urandom), ($urandom_range(0, 2) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised multi-port GPIO peripheral for the PacoBlaze3 port bus, the successor to the fixed single-direction `outport`/`inport` pair. It provides NPORTS 8-bit ports, each with per-bit direction, a two-flop input synchronizer, rising-edge capture with per-bit enable, and a level interrupt request to the processor. It sits beside the core on the `port_id`/`out_port`/`in_port` bus.

## Interface
- BASE_ADDR, 8'h10, first register address; must be a multiple of 4.
- NPORTS, 2, number of 8-bit ports, 1..8; requires BASE_ADDR + 4*NPORTS <= 255.

- clk  in  1  system clock
- rst  in  1  reset; one clock, synchronous, active-high
- port_id  in  8  PacoBlaze port address
- out_port  in  8  PacoBlaze write data
- write_strobe  in  1  write qualifier, one cycle
- read_strobe  in  1  read qualifier; no side effects, accepted but unused
- in_port  out  8  registered read data
- gpio_in  in  8*NPORTS  asynchronous pin inputs; port k is bits [8k+7:8k]
- gpio_out  out  8*NPORTS  output latches
- gpio_oe  out  8*NPORTS  direction; 1 = output-enable
- irq  out  1  interrupt request to core, level, active-high

## Operation
Register map, with port k at A = BASE_ADDR + 4k:
- A+0 DATA
  - Write: loads the output latch.
  - Read: (oe & latch) | (~oe & sync2).
- A+1 DIR: read/write `gpio_oe` bits.
- A+2 IE: read/write rising-edge interrupt enable.
- A+3 IFLAG
  - Read: returns the pending edge flags.
  - Write: 1 clears the bit; 0 has no effect.
- BASE_ADDR + 4*NPORTS, SUMMARY (read-only): bit k = |(IFLAG_k & IE_k). Bits >= NPORTS read 0; writes are ignored.
- Any other address: reads 8'h00; writes are ignored.

Input path, per bit:
- `sync1 <= gpio_in`, `sync2 <= sync1`, `prev <= sync2`.
- `prev` updates every cycle regardless of DIR, so a direction change never fabricates an edge.
- edge = sync2 & ~prev & ~oe & armed.
- Flag update: IFLAG <= (IFLAG & ~clr) | edge. On a simultaneous set and clear, **set wins**.
- Flags latch whatever IE is set to; IE only gates irq.

Arming after reset:
- A 2-bit counter holds `armed` = 0 for the first 3 cycles after rst deasserts, while the synchronizer pipeline fills.
- A pin held high through reset therefore never sets a flag.

irq:
- irq <= |(all IFLAG & IE), registered.
- It stays high until software clears the flags or IE.
- No acknowledge handshake.

Reset (rst high at a clock edge) sets all of the following to 0:
- gpio_out, gpio_oe, IE, IFLAG
- sync1, sync2, prev
- armed counter, in_port, irq

Reset mid-operation discards pending flags and any read in flight.

## Timing
- Write: registers update at the clk edge where write_strobe = 1 and port_id matches. gpio_out/gpio_oe are visible after that edge, so latency is 1.
- Read: in_port <= decode(port_id) every edge, independent of read_strobe.
  - PacoBlaze3 holds port_id for 2 cycles and samples in_port at the end of the second, so registered data is valid in time.
  - Data reflects state at the first edge of the INPUT instruction.
- Pin-to-readback: a pin change before edge n is visible in sync2 after edge n+1 and readable from edge n+2.
- Pin-to-flag: an edge arriving before clock edge n sets IFLAG after edge n+2. irq follows after edge n+3.
- Clear-to-irq: an IFLAG write-clear at edge m drops irq after edge m+1, unless a new edge re-sets the flag.
- Register writes and flag updates are single-cycle. There is no back-pressure and no busy state.

## Test plan
- **Reset with pin high:** reset with gpio_in all 8'hFF, release, run 10 cycles.
  - gpio_out = gpio_oe = 0, in_port = 0, irq = 0.
  - IFLAG reads 8'h00, so no spurious edge.
- **Output and readback:** on port 0 write DIR = 8'h0F, DATA = 8'hA5, with gpio_in[7:0] = 8'h3C.
  - gpio_out[7:0] = 8'hA5 and gpio_oe[7:0] = 8'h0F one cycle after the write strobe.
  - DATA reads 8'h35.
- **Edge capture and irq:** on port 1 set IE = 8'h01; raise gpio_in[8] at edge n.
  - IFLAG1 = 8'h01 after n+2, irq = 1 after n+3, SUMMARY reads 8'h02.
  - Writing IFLAG1 = 8'h01 drops irq one cycle later.
- **Set/clear collision:** time an edge on bit 3 to land in the same cycle as a write-1-clear of bit 3.
  - The flag remains 1.
  - A following clear with no edge yields 0.
- **Direction switch:** bit 2 is an output driven 0 while the pin is held 1; switch DIR to input.
  - No flag sets.
  - A later 0 -> 1 transition on the pin sets the flag.
- **Unmapped and reset mid-operation:** read BASE_ADDR + 4*NPORTS + 1 and a write to it; then assert rst while irq = 1.
  - The unmapped read returns 8'h00 and the write changes nothing.
  - After the reset edge, irq = 0 and all flags are 0.
